// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the parametrised inter-stage pipeline
// register (pipe_stage_buf) and its helpers.
//   - state_t / ST_*  : handshake FSM state encoding (EMPTY, ONE, TWO)
//   - OCC_*           : occupancy values reported on the occupancy port
//   - PERF_CNT_W_DEFAULT : default width of the optional perf counters
//   - occ_of()        : maps an FSM state to its occupancy value
package pipe_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_EMPTY = 2'd0;
  localparam state_t ST_ONE   = 2'd1;
  localparam state_t ST_TWO   = 2'd2;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  localparam int PERF_CNT_W_DEFAULT = 32;

  function automatic logic [1:0] occ_of(input state_t st);
    case (st)
      ST_ONE:  occ_of = OCC_ONE;
      ST_TWO:  occ_of = OCC_TWO;
      default: occ_of = OCC_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous, active-high reset (clears count)
//   inc   - increment request for this cycle
//   count - current count value
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: generic inter-stage pipeline register with a valid/ready
// handshake and a 2-entry skid buffer. in_ready comes straight from a flop,
// so no combinational ready path crosses the stage. Flush empties the stage
// and drops the coincident input; invalid slots always read as all-zero
// (a NOP bubble).
// Optional feature macro: PIPE_STAGE_PERF_EN adds saturating stall/bubble
// counters (ports stall_cnt and bubble_cnt exist only when it is defined).
// Ports:
//   clk, rst           - clock (rising edge), async active-high reset
//   flush              - synchronous exception flush
//   in_valid/in_ready  - upstream handshake (in_ready registered)
//   in_data            - upstream payload, DATA_W bits
//   out_valid/out_ready- downstream handshake
//   out_data           - downstream payload, zero when out_valid=0
//   occupancy          - entries held (0, 1 or 2)
//   stall_cnt          - cycles with out_valid & ~out_ready (perf only)
//   bubble_cnt         - cycles with out_ready & ~out_valid (perf only)
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CNT_W  = PERF_CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] main_reg, main_next;
  logic [DATA_W-1:0] skid_reg, skid_next;
  logic              in_ready_reg;
  logic              in_fire, out_fire;

  assign in_fire  = in_valid & in_ready_reg;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    if (flush) begin
      state_next = ST_EMPTY;
      main_next  = '0;
      skid_next  = '0;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (in_fire) begin
            state_next = ST_ONE;
            main_next  = in_data;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_next = in_data;
          end else if (in_fire) begin
            state_next = ST_TWO;
            skid_next  = in_data;
          end else if (out_fire) begin
            state_next = ST_EMPTY;
            main_next  = '0;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the drain can happen.
          if (out_fire) begin
            state_next = ST_ONE;
            main_next  = skid_reg;
            skid_next  = '0;
          end
        end
        default: begin
          state_next = ST_EMPTY;
          main_next  = '0;
          skid_next  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_EMPTY;
      main_reg     <= '0;
      skid_reg     <= '0;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      main_reg     <= main_next;
      skid_reg     <= skid_next;
      // Registered ready: look ahead at the next state so a full stage
      // deasserts ready on the same edge it fills.
      in_ready_reg <= (state_next != ST_TWO);
    end
  end

  // main_reg is kept at zero whenever the stage is empty, so it can drive
  // out_data directly and still present a zero bubble.
  assign out_valid = (state_reg != ST_EMPTY);
  assign out_data  = main_reg;
  assign in_ready  = in_ready_reg;
  assign occupancy = occ_of(state_reg);

`ifdef PIPE_STAGE_PERF_EN
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid & ~out_ready),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_ready & ~out_valid),
    .count (bubble_cnt)
  );
`else
  // Counter width only matters when the perf counters are built.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] bubble_cnt;
`endif

  int checks;
  int failures;

  pipe_stage_buf #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          fl;
    logic          iv;
    logic [DW-1:0] id;
    logic          ordy;
    logic          e_ov;
    logic [DW-1:0] e_od;
    logic          e_ir;
    logic [1:0]    e_occ;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic ov, input logic [DW-1:0] od,
                          input logic ir, input logic [1:0] occ);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".out_data"},  32'(out_data),  32'(od));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(ir));
    chk({tag, ".occupancy"}, 32'(occupancy), 32'(occ));
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [DW-1:0] id, input logic ordy);
    flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic fl, input logic iv, input logic [DW-1:0] id,
                              input logic ordy, input logic ov, input logic [DW-1:0] od,
                              input logic ir, input logic [1:0] occ);
    vec_t v;
    v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
    v.e_ov = ov; v.e_od = od; v.e_ir = ir; v.e_occ = occ;
    return v;
  endfunction

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0);

    // Expected values are the outputs seen before the edge that applies the inputs.
    vecs[0]  = mk(0, 1, 8'h0A, 0, 0, 8'h00, 1, 0);
    vecs[1]  = mk(0, 1, 8'h0B, 0, 1, 8'h0A, 1, 1);
    vecs[2]  = mk(0, 1, 8'h0C, 0, 1, 8'h0A, 0, 2);
    vecs[3]  = mk(0, 0, 8'h00, 0, 1, 8'h0A, 0, 2);
    vecs[4]  = mk(0, 0, 8'h00, 1, 1, 8'h0A, 0, 2);
    vecs[5]  = mk(0, 0, 8'h00, 1, 1, 8'h0B, 1, 1);
    vecs[6]  = mk(0, 0, 8'h00, 1, 0, 8'h00, 1, 0);
    vecs[7]  = mk(0, 1, 8'h01, 1, 0, 8'h00, 1, 0);
    vecs[8]  = mk(0, 1, 8'h02, 1, 1, 8'h01, 1, 1);
    vecs[9]  = mk(0, 1, 8'h03, 1, 1, 8'h02, 1, 1);
    vecs[10] = mk(0, 0, 8'h00, 1, 1, 8'h03, 1, 1);
    vecs[11] = mk(0, 1, 8'h0D, 0, 0, 8'h00, 1, 0);
    vecs[12] = mk(0, 1, 8'h0E, 0, 1, 8'h0D, 1, 1);
    vecs[13] = mk(1, 1, 8'h0C, 0, 1, 8'h0D, 0, 2);
    vecs[14] = mk(0, 0, 8'h00, 1, 0, 8'h00, 1, 0);
    vecs[15] = mk(1, 1, 8'h05, 1, 0, 8'h00, 1, 0);
    vecs[16] = mk(0, 0, 8'h00, 0, 0, 8'h00, 1, 0);

    // Reset state while rst is held.
    #2;
    chk_outs("reset", 1'b0, 8'h00, 1'b1, 2'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors: backpressure, drain order, flush, flush while empty.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(vecs[i].fl, vecs[i].iv, vecs[i].id, vecs[i].ordy);
      #1;
      chk_outs($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_od, vecs[i].e_ir, vecs[i].e_occ);
      $display("vec %0d fl=%0b iv=%0b id=%02h ordy=%0b -> ov=%0b od=%02h ir=%0b occ=%0d",
               i, vecs[i].fl, vecs[i].iv, vecs[i].id, vecs[i].ordy,
               out_valid, out_data, in_ready, occupancy);
    end

    // Streaming 0x1..0x10 with out_ready held high: 1-cycle latency, ready never drops.
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, DW'(i), 1'b1);
      #1;
      chk($sformatf("stream%0d.in_ready", i), 32'(in_ready), 32'd1);
      if (i == 1) chk("stream1.out_valid", 32'(out_valid), 32'd0);
      else        chk($sformatf("stream%0d.out_data", i), 32'({out_valid, out_data}), 32'({1'b1, DW'(i - 1)}));
      $display("stream push=%02h ov=%0b od=%02h", i, out_valid, out_data);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, '0, 1'b1);
    #1;
    chk("stream_last.out_data", 32'({out_valid, out_data}), 32'({1'b1, 8'h10}));
    @(negedge clk);
    #1;
    chk_outs("stream_empty", 1'b0, 8'h00, 1'b1, 2'd0);

    // Simultaneous in_fire & out_fire in state ONE for 8 cycles.
    @(negedge clk);
    drive(1'b0, 1'b1, 8'h20, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, DW'(8'h21 + k), 1'b1);
      #1;
      chk($sformatf("simul%0d.occupancy", k), 32'(occupancy), 32'd1);
      chk($sformatf("simul%0d.out_data", k), 32'(out_data), 32'(8'h20 + k));
      $display("simul k=%0d occ=%0d od=%02h", k, occupancy, out_data);
    end

    // Async reset with two entries held: outputs clear before any clock edge.
    do_reset();
    @(negedge clk); drive(1'b0, 1'b1, 8'h31, 1'b0);
    @(negedge clk); drive(1'b0, 1'b1, 8'h32, 1'b0);
    @(negedge clk); drive(1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    chk("pre_rst.occupancy", 32'(occupancy), 32'd2);
    rst = 1'b1;
    #1;
    chk_outs("async_rst", 1'b0, 8'h00, 1'b1, 2'd0);
    $display("async_rst ov=%0b od=%02h ir=%0b occ=%0d", out_valid, out_data, in_ready, occupancy);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk_outs("post_rst", 1'b0, 8'h00, 1'b1, 2'd0);

`ifdef PIPE_STAGE_PERF_EN
    do_reset();
    #1;
    chk("perf_rst.stall", 32'(stall_cnt), 32'd0);
    chk("perf_rst.bubble", 32'(bubble_cnt), 32'd0);
    @(negedge clk); drive(1'b0, 1'b1, 8'h41, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); drive(1'b0, 1'b0, 8'h00, 1'b0);
    end
    @(negedge clk); drive(1'b0, 1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); drive(1'b0, 1'b0, 8'h00, 1'b1);
    end
    @(negedge clk); drive(1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    chk("perf.stall", 32'(stall_cnt), 32'd5);
    chk("perf.bubble", 32'(bubble_cnt), 32'd3);
    $display("perf stall=%0d bubble=%0d", stall_cnt, bubble_cnt);
    @(negedge clk); drive(1'b1, 1'b0, 8'h00, 1'b0);
    @(negedge clk); drive(1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    chk("perf_flush.stall", 32'(stall_cnt), 32'd5);
    chk("perf_flush.bubble", 32'(bubble_cnt), 32'd3);
    drive(1'b0, 1'b1, 8'h42, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); drive(1'b0, 1'b0, 8'h00, 1'b0);
    end
    #1;
    chk("perf_sat.stall", 32'(stall_cnt), 32'd15);
    $display("perf_sat stall=%0d", stall_cnt);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Generic, parametrised inter-stage pipeline register for the back end: successor to the fixed-field pause-vector stage registers.
- Carries an opaque payload of DATA_W bits, packed by the instantiating stage.
- Uses a valid/ready handshake with a 2-entry skid buffer, so in_ready is registered and no combinational ready path crosses the stage.
- Supports exception flush; invalid slots read as an all-zero payload (zero = NOP bubble).

Parameters:
- DATA_W, 128, payload width in bits (≥1).
- CNT_W, 32, perf counter width; used only with PIPE_STAGE_PERF_EN.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  exception flush; discards all held entries and the current input
- in_valid  in  1  upstream payload valid
- in_ready  out  1  stage can accept; registered
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  downstream payload valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  downstream payload; zero when out_valid=0
- occupancy  out  2  entries held: 0, 1 or 2
- stall_cnt  out  CNT_W  only with PIPE_STAGE_PERF_EN
- bubble_cnt  out  CNT_W  only with PIPE_STAGE_PERF_EN

Behaviour:
- Reset (async, rst=1):
  - state EMPTY; out_valid=0, out_data=0, in_ready=1, occupancy=0.
  - skid register = 0; perf counters = 0.
- Storage:
  - main register drives out_data/out_valid.
  - skid register holds the overflow entry.
- Fire definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- State machine, evaluated per rising edge when rst=0 and flush=0:
  - EMPTY: in_fire → ONE, main <= in_data.
  - ONE:
    - in_fire & out_fire → ONE, main <= in_data.
    - in_fire only → TWO, skid <= in_data.
    - out_fire only → EMPTY, main <= 0.
    - neither → ONE, hold.
  - TWO: in_ready=0.
    - out_fire → ONE, main <= skid, skid <= 0.
    - otherwise hold.
- Outputs:
  - in_ready = registered (next state != TWO).
  - occupancy = 0/1/2 for EMPTY/ONE/TWO.
- Latency: 1 cycle from in_fire to out_valid when empty. Throughput 1 per cycle with out_ready held high.
- Ordering: strict FIFO; no payload is duplicated or dropped except by flush.
- flush (synchronous, priority below rst, above everything else):
  - next state EMPTY; main, skid <= 0; in_ready <= 1.
  - An in_fire coincident with flush is discarded.
  - An out_fire coincident with flush still counts as consumed downstream; this is not a double issue.
- Hold: out_data stays stable while out_valid & ~out_ready, through any number of cycles.
- Reset mid-operation: all entries are lost immediately (async); no partial state survives.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt increments each cycle out_valid & ~out_ready.
  - bubble_cnt increments each cycle out_ready & ~out_valid.
  - Both saturate at all-ones.
  - Both are cleared only by rst; flush does not clear them.
- Undefined: both ports and all counter logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - state encoding typedef (EMPTY=2'd0, ONE=2'd1, TWO=2'd2).
  - occupancy constants.
  - default CNT_W.
- Sub-module sat_counter (parameter W; inc input, async rst) for the two perf counters; instantiated only under PIPE_STAGE_PERF_EN.
- Handshake FSM and data path stay in the top module.

Test Plan:
- Reset: assert rst mid-cycle with 2 entries held → out_valid=0, out_data=0, in_ready=1, occupancy=0 immediately, without waiting for a clock edge.
- Streaming: out_ready=1, push 0x1..0x10 back-to-back → identical sequence out, 1-cycle latency, in_ready never drops.
- Backpressure: out_ready=0, push 0xA, 0xB → occupancy=2, in_ready=0, out_data=0xA held. Release out_ready → 0xA then 0xB, in_ready=1 the cycle after 0xA leaves.
- Flush: occupancy=2 with in_valid=1 (data 0xC) during the flush cycle → next cycle occupancy=0, out_valid=0, out_data=0; 0xC is never emitted.
- Simultaneous events: state ONE with in_fire & out_fire every cycle for 8 cycles → occupancy stays 1, order preserved.
- PIPE_STAGE_PERF_EN: 5 cycles valid & ~ready, then 3 cycles ready & ~valid → stall_cnt=5, bubble_cnt=3. Counters unchanged by flush. Counters with CNT_W=4 saturate at 15.
